// File: rtl/rholang_loader_pkg.sv
// Shared definitions for the program loader: state encoding, error codes, header layout.
package rholang_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_HEADER = 3'd1,
      ST_BODY   = 3'd2,
      ST_CHECK  = 3'd3,
      ST_HOLD   = 3'd4
   } load_state_e;

   localparam logic [1:0] ERR_NONE     = 2'd0;
   localparam logic [1:0] ERR_MAGIC    = 2'd1;
   localparam logic [1:0] ERR_LENGTH   = 2'd2;
   localparam logic [1:0] ERR_CHECKSUM = 2'd3;

   localparam logic [15:0] DEFAULT_LOAD_MAGIC = 16'hB0C0;

   localparam int unsigned HDR_MAGIC_HI = 31;
   localparam int unsigned HDR_MAGIC_LO = 16;
   localparam int unsigned HDR_LEN_HI   = 15;
   localparam int unsigned HDR_LEN_LO   = 0;

endpackage

// File: rtl/rholang_program_loader.sv
// Parses a header/body/checksum word stream and writes the body into instruction memory.
module rholang_program_loader
   import rholang_loader_pkg::*;
#(
   parameter int unsigned IMEM_ADDR_W = 10,
   parameter logic [15:0] LOAD_MAGIC  = DEFAULT_LOAD_MAGIC
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [31:0]            program_data,
   input  logic                   program_valid,
   output logic                   program_ready,
   input  logic                   load_enable,
   output logic                   imem_we,
   output logic [IMEM_ADDR_W-1:0] imem_addr,
   output logic [31:0]            imem_wdata,
   output logic                   busy,
   output logic                   load_done,
   output logic                   load_error,
   output logic [1:0]             error_code,
   output logic [IMEM_ADDR_W:0]   words_loaded
);

   localparam int unsigned CNT_W   = IMEM_ADDR_W + 1;
   localparam logic [31:0] MAX_LEN = 32'(1) << IMEM_ADDR_W;

   load_state_e            state_q;
   load_state_e            state_d;
   logic [CNT_W-1:0]       len_q;
   logic [31:0]            acc_q;
   logic [IMEM_ADDR_W-1:0] addr_q;

   logic        xfer;
   logic [15:0] hdr_len;
   logic        magic_ok;
   logic        len_ok;
   logic        last_body;

   // Transfer qualification and header decode; an abort (enable low) wins over a transfer
   always_comb begin
      xfer      = program_valid && program_ready && load_enable;
      hdr_len   = program_data[HDR_LEN_HI:HDR_LEN_LO];
      magic_ok  = (program_data[HDR_MAGIC_HI:HDR_MAGIC_LO] == LOAD_MAGIC);
      len_ok    = (hdr_len != 16'd0) && (32'(hdr_len) <= MAX_LEN);
      last_body = (CNT_W'(words_loaded + CNT_W'(1)) == len_q);
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (load_enable) state_d = ST_HEADER;
         end
         ST_HEADER: begin
            if (!load_enable) begin
               state_d = ST_IDLE;
            end else if (xfer) begin
               state_d = (magic_ok && len_ok) ? ST_BODY : ST_HOLD;
            end
         end
         ST_BODY: begin
            if (!load_enable) begin
               state_d = ST_IDLE;
            end else if (xfer && last_body) begin
               state_d = ST_CHECK;
            end
         end
         ST_CHECK: begin
            if (!load_enable) begin
               state_d = ST_IDLE;
            end else if (xfer) begin
               state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (!load_enable) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State-decoded outputs; no combinational path from inputs
   always_comb begin
      program_ready = 1'b0;
      busy          = 1'b0;
      load_error    = 1'b0;
      case (state_q)
         ST_HEADER, ST_BODY, ST_CHECK: begin
            program_ready = 1'b1;
            busy          = 1'b1;
         end
         ST_HOLD: load_error = (error_code != ERR_NONE);
         default: ;
      endcase
   end

   // Datapath: header latch, body write register, accumulator, counters, status
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         len_q        <= '0;
         acc_q        <= '0;
         addr_q       <= '0;
         imem_we      <= 1'b0;
         imem_addr    <= '0;
         imem_wdata   <= '0;
         load_done    <= 1'b0;
         error_code   <= ERR_NONE;
         words_loaded <= '0;
      end else begin
         imem_we   <= 1'b0;
         load_done <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (load_enable) begin
                  len_q        <= '0;
                  acc_q        <= '0;
                  addr_q       <= '0;
                  error_code   <= ERR_NONE;
                  words_loaded <= '0;
               end
            end
            ST_HEADER: begin
               if (xfer) begin
                  if (!magic_ok) begin
                     error_code <= ERR_MAGIC;
                  end else if (!len_ok) begin
                     error_code <= ERR_LENGTH;
                  end else begin
                     len_q <= CNT_W'(hdr_len);
                  end
               end
            end
            ST_BODY: begin
               if (xfer) begin
                  imem_we      <= 1'b1;
                  imem_addr    <= addr_q;
                  imem_wdata   <= program_data;
                  addr_q       <= addr_q + IMEM_ADDR_W'(1);
                  acc_q        <= acc_q + program_data;
                  words_loaded <= words_loaded + CNT_W'(1);
               end
            end
            ST_CHECK: begin
               if (xfer) begin
                  if (program_data == acc_q) begin
                     load_done <= 1'b1;
                  end else begin
                     error_code <= ERR_CHECKSUM;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_rholang_program_loader.sv
// Scoreboard bench for rholang_program_loader: expected writes queued at stimulus, checked on output.
module tb_rholang_program_loader;

   localparam int unsigned AW = 10;

   logic          clk = 1'b0;
   logic          reset;
   logic [31:0]   program_data;
   logic          program_valid;
   logic          program_ready;
   logic          load_enable;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic          busy;
   logic          load_done;
   logic          load_error;
   logic [1:0]    error_code;
   logic [AW:0]   words_loaded;

   int tests = 0;
   int fails = 0;
   int done_pulses = 0;

   logic [AW-1:0] exp_addr_q[$];
   logic [31:0]   exp_data_q[$];

   rholang_program_loader #(.IMEM_ADDR_W(AW), .LOAD_MAGIC(16'hB0C0)) dut (
      .clk           (clk),
      .reset         (reset),
      .program_data  (program_data),
      .program_valid (program_valid),
      .program_ready (program_ready),
      .load_enable   (load_enable),
      .imem_we       (imem_we),
      .imem_addr     (imem_addr),
      .imem_wdata    (imem_wdata),
      .busy          (busy),
      .load_done     (load_done),
      .load_error    (load_error),
      .error_code    (error_code),
      .words_loaded  (words_loaded)
   );

   always #5 clk = ~clk;

   // Write monitor: every observed write must match the head of the scoreboard
   always @(negedge clk) begin
      if (!reset && load_done) done_pulses++;
      if (!reset && imem_we) begin
         tests++;
         if (exp_addr_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_write: addr=%h data=%h, required no write", imem_addr, imem_wdata);
         end else begin
            logic [AW-1:0] ea;
            logic [31:0]   ed;
            ea = exp_addr_q.pop_front();
            ed = exp_data_q.pop_front();
            if (imem_addr !== ea || imem_wdata !== ed) begin
               fails++;
               $display("FAIL write: addr=%h data=%h, required addr=%h data=%h", imem_addr, imem_wdata, ea, ed);
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Present one word and hold it until it transfers (bounded)
   task automatic send_word(input logic [31:0] d);
      int n;
      n = 0;
      program_data  = d;
      program_valid = 1'b1;
      while (!program_ready && n < 50) begin
         tick(1);
         n++;
      end
      if (!program_ready) begin
         tests++;
         fails++;
         $display("FAIL ready_timeout: ready=%b, required 1", program_ready);
      end else begin
         tick(1);
      end
      program_valid = 1'b0;
   endtask

   task automatic send_body(input logic [31:0] d, input logic [AW-1:0] a);
      exp_addr_q.push_back(a);
      exp_data_q.push_back(d);
      send_word(d);
   endtask

   task automatic start_load();
      load_enable = 1'b1;
   endtask

   task automatic end_load();
      load_enable = 1'b0;
      tick(2);
      tests++;
      if (busy !== 1'b0 || load_error !== 1'b0 || program_ready !== 1'b0) begin
         fails++;
         $display("FAIL idle_after_drop: busy=%b err=%b ready=%b, required 0/0/0", busy, load_error, program_ready);
      end
      tests++;
      if (exp_addr_q.size() != 0) begin
         fails++;
         $display("FAIL missing_writes: %0d pending, required 0", exp_addr_q.size());
         exp_addr_q.delete();
         exp_data_q.delete();
      end
   endtask

   task automatic check_result(input string name, input logic [1:0] code, input logic done,
                               input logic [AW:0] wl);
      tests++;
      if (error_code !== code || load_error !== (code != 2'd0) || load_done !== done ||
          busy !== 1'b0 || words_loaded !== wl) begin
         fails++;
         $display("FAIL %s: code=%0d err=%b done=%b busy=%b words=%0d, required code=%0d err=%b done=%b busy=0 words=%0d",
                  name, error_code, load_error, load_done, busy, words_loaded, code, (code != 2'd0), done, wl);
      end
   endtask

   task automatic test_reset();
      tick(2);
      tests++;
      if (program_ready !== 0 || imem_we !== 0 || imem_addr !== '0 || imem_wdata !== 0 || busy !== 0 ||
          load_done !== 0 || load_error !== 0 || error_code !== 0 || words_loaded !== '0) begin
         fails++;
         $display("FAIL reset_state: ready=%b we=%b busy=%b done=%b err=%b code=%0d words=%0d, required all 0",
                  program_ready, imem_we, busy, load_done, load_error, error_code, words_loaded);
      end
      reset = 1'b0;
      tick(1);
   endtask

   task automatic test_good_load();
      int d0;
      d0 = done_pulses;
      start_load();
      send_word(32'hB0C0_0003);
      send_body(32'h0000_0001, 10'd0);
      send_body(32'h0000_0002, 10'd1);
      send_body(32'hFFFF_FFFF, 10'd2);
      send_word(32'h0000_0002);
      check_result("good_load", 2'd0, 1'b1, 11'd3);
      tick(1);
      tests++;
      if (load_done !== 1'b0 || done_pulses - d0 != 1) begin
         fails++;
         $display("FAIL good_done_pulse: done=%b pulses=%0d, required 0 and 1 pulse", load_done, done_pulses - d0);
      end
      end_load();
   endtask

   task automatic test_bad_magic();
      start_load();
      send_word(32'h1234_0003);
      check_result("bad_magic", 2'd1, 1'b0, 11'd0);
      tick(3);
      tests++;
      if (program_ready !== 1'b0 || load_error !== 1'b1) begin
         fails++;
         $display("FAIL hold_magic: ready=%b err=%b, required 0/1", program_ready, load_error);
      end
      end_load();
   endtask

   task automatic test_bad_length();
      logic [31:0] hdrs[2];
      hdrs[0] = 32'hB0C0_0000;
      hdrs[1] = 32'hB0C0_0401;
      for (int i = 0; i < 2; i++) begin
         start_load();
         send_word(hdrs[i]);
         check_result("bad_length", 2'd2, 1'b0, 11'd0);
         end_load();
      end
   endtask

   task automatic test_max_length();
      logic [31:0] sum;
      logic [31:0] w;
      int d0;
      d0 = done_pulses;
      sum = 32'd0;
      start_load();
      send_word(32'hB0C0_0400);
      for (int i = 0; i < 1024; i++) begin
         w = $urandom;
         sum = sum + w;
         send_body(w, AW'(i));
      end
      send_word(sum);
      check_result("max_length", 2'd0, 1'b1, 11'd1024);
      tick(1);
      tests++;
      if (done_pulses - d0 != 1) begin
         fails++;
         $display("FAIL max_done_pulse: pulses=%0d, required 1", done_pulses - d0);
      end
      end_load();
   endtask

   task automatic test_bad_checksum();
      int d0;
      d0 = done_pulses;
      start_load();
      send_word(32'hB0C0_0003);
      send_body(32'h0000_0001, 10'd0);
      send_body(32'h0000_0002, 10'd1);
      send_body(32'hFFFF_FFFF, 10'd2);
      send_word(32'h0000_0003);
      check_result("bad_checksum", 2'd3, 1'b0, 11'd3);
      tick(2);
      tests++;
      if (done_pulses != d0) begin
         fails++;
         $display("FAIL checksum_no_done: pulses=%0d, required 0", done_pulses - d0);
      end
      end_load();
   endtask

   task automatic test_stalls();
      start_load();
      send_word(32'hB0C0_0003);
      send_body(32'h0000_0001, 10'd0);
      tick(2);
      tests++;
      if (words_loaded !== 11'd1 || busy !== 1'b1) begin
         fails++;
         $display("FAIL stall_hold: words=%0d busy=%b, required 1/1", words_loaded, busy);
      end
      send_body(32'h0000_0002, 10'd1);
      tick(1);
      send_body(32'hFFFF_FFFF, 10'd2);
      send_word(32'h0000_0002);
      check_result("stall_load", 2'd0, 1'b1, 11'd3);
      end_load();
   endtask

   task automatic test_abort();
      int d0;
      d0 = done_pulses;
      start_load();
      send_word(32'hB0C0_0005);
      send_body(32'h0000_00AA, 10'd0);
      send_body(32'h0000_00BB, 10'd1);
      load_enable = 1'b0;
      tick(1);
      check_result("abort", 2'd0, 1'b0, 11'd2);
      tests++;
      if (done_pulses != d0 || program_ready !== 1'b0) begin
         fails++;
         $display("FAIL abort_idle: pulses=%0d ready=%b, required 0/0", done_pulses - d0, program_ready);
      end
      end_load();
   endtask

   task automatic test_reset_mid_load();
      start_load();
      send_word(32'hB0C0_0004);
      send_word(32'h0000_0011);
      tests++;
      if (imem_we !== 1'b1 || words_loaded !== 11'd1) begin
         fails++;
         $display("FAIL pre_reset: we=%b words=%0d, required 1/1", imem_we, words_loaded);
      end
      #1;
      reset = 1'b1;
      #1;
      tests++;
      if (imem_we !== 0 || busy !== 0 || program_ready !== 0 || words_loaded !== '0 ||
          load_done !== 0 || load_error !== 0 || error_code !== 0 || imem_addr !== '0 || imem_wdata !== 0) begin
         fails++;
         $display("FAIL async_reset: we=%b busy=%b ready=%b words=%0d, required all 0",
                  imem_we, busy, program_ready, words_loaded);
      end
      load_enable = 1'b0;
      tick(1);
      reset = 1'b0;
      tick(1);
   endtask

   initial begin
      reset         = 1'b1;
      program_data  = 32'd0;
      program_valid = 1'b0;
      load_enable   = 1'b0;
      test_reset();
      test_good_load();
      test_bad_magic();
      test_bad_length();
      test_max_length();
      test_bad_checksum();
      test_stalls();
      test_abort();
      test_reset_mid_load();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/rholang_program_loader.md
# rholang_program_loader

Consumes the 32-bit program word stream emitted by the Linux interface controller (`program_data` / `program_valid` / `program_ready`) and writes the validated image into the FSM core's instruction memory. It parses a header word, writes body words sequentially, and verifies a trailing checksum. It reports completion or a coded error to the core sequencer and to the status register bank.

## Interface

**Parameters**
- `IMEM_ADDR_W`, default 10: instruction memory address width; depth = 2^IMEM_ADDR_W words.
- `LOAD_MAGIC`, default 16'hB0C0: required value of header bits [31:16].

**Ports**
- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-high.
- `program_data` in 32: stream word.
- `program_valid` in 1: stream word present.
- `program_ready` out 1: loader accepts the word this cycle.
- `load_enable` in 1: arms a load; deassertion aborts it.
- `imem_we` out 1: instruction memory write strobe.
- `imem_addr` out IMEM_ADDR_W: write address.
- `imem_wdata` out 32: write data.
- `busy` out 1: state is HEADER, BODY or CHECK.
- `load_done` out 1: one-cycle pulse on a successful load.
- `load_error` out 1: error flag, held in HOLD.
- `error_code` out 2: 0 none, 1 bad magic, 2 bad length, 3 checksum mismatch.
- `words_loaded` out IMEM_ADDR_W+1: count of body words written.

## Operation

- **Transfer:** a word transfers on a rising edge where `program_valid && program_ready`. `program_ready` is decoded from the state register only and has no combinational path from inputs. It is 1 in HEADER, BODY and CHECK.
- **Image format:** header, then N body words, then a checksum word.
  - Header [31:16] = LOAD_MAGIC; [15:0] = N.
  - N is valid when 1 ≤ N ≤ 2^IMEM_ADDR_W.
  - Checksum = sum of the body words mod 2^32.
- **States:**
  - IDLE → HEADER when `load_enable`=1. Entry clears `words_loaded`, `error_code`, the accumulator and the address counter.
  - HEADER, on transfer:
    - magic mismatch → HOLD, code 1;
    - N invalid → HOLD, code 2;
    - otherwise latch N → BODY.
  - BODY, on transfer of word k: write at address k, add the word to the accumulator, increment `words_loaded`. After the Nth word → CHECK.
  - CHECK, on transfer:
    - equal to accumulator → pulse `load_done`, then HOLD with code 0;
    - otherwise → HOLD, code 3.
  - HOLD: `program_ready`=0. `load_error` = (code≠0). Exit to IDLE when `load_enable`=0.
- **Abort:** `load_enable`=0 in HEADER, BODY or CHECK → IDLE next edge.
  - No done pulse, no error.
  - Words already written stay written; `words_loaded` keeps its value.
- **Body writes are not rolled back on error.** Consumers use `load_done` / `load_error` to qualify the image.
- **Arithmetic:** the accumulator is 32 bits and wraps. The address counter is IMEM_ADDR_W bits. With N = 2^IMEM_ADDR_W, the last word is written at the all-ones address; the counter wrap to 0 is harmless because BODY exits on the count, not the address.
- **Reset values:** state IDLE; all outputs 0; accumulator, counters and N cleared.
- **Reset mid-load:** asynchronous return to IDLE; any in-flight `imem_we` is dropped.

## Timing

- Throughput: one word per cycle when `program_valid` is held high.
- Write latency: `imem_we` / `imem_addr` / `imem_wdata` are registered and appear 1 cycle after the body word's transfer edge.
- `load_done`: high exactly one cycle, starting the cycle after the checksum transfer. `load_error` and `error_code` update in the same cycle.
- `busy` falls in the same cycle that `load_done` or the error rises.
- Minimum load: N + 2 transfer cycles plus 1 cycle IDLE→HEADER.
- Valid low during BODY: stall with no write and no state change.

## Structure

- **Shared package `rholang_loader_pkg`:**
  - state encoding: IDLE, HEADER, BODY, CHECK, HOLD;
  - error code constants;
  - LOAD_MAGIC default;
  - header field positions (MAGIC [31:16], LEN [15:0]).
- **Sub-module:** none. The FSM, counters, accumulator and write register stay in one module.

## Test plan

- **Good load:** header B0C0_0003, body 1, 2, 0xFFFF_FFFF, checksum 0x0000_0002 → writes at addresses 0/1/2; one `load_done` pulse; `error_code`=0; `words_loaded`=3.
- **Bad magic:** header 1234_0003 → HOLD with `error_code`=1 and `load_error`=1; `imem_we` never asserted; IDLE after `load_enable` drops.
- **Bad length:** headers B0C0_0000 and B0C0_0401 (IMEM_ADDR_W=10) → `error_code`=2 for both. Header B0C0_0400 with 1024 words and the correct checksum → done; last write at address 0x3FF.
- **Bad checksum:** same image as the good load with checksum 3 → all 3 words written; `error_code`=3; no `load_done`.
- **Stalls:** `program_valid` toggled 1,0,0,1 between body words → the gap shifts writes by the stall cycles; result matches the good load.
- **Abort and reset:**
  - `load_enable` dropped after 2 of 5 body words → IDLE; `words_loaded`=2; no done, no error.
  - Async `reset` pulse mid-BODY → all outputs 0 immediately.
